// File: rtl/isa_pkg.sv
// ISA constants shared by the program loader and its instruction encoder:
// opcodes, ALU function codes, instruction field positions, error codes and loader states.
package isa_pkg;

    localparam logic [3:0] OP_RTYPE       = 4'd0;
    localparam logic [3:0] OP_LOAD_IM     = 4'd1;
    localparam logic [3:0] OP_LOAD        = 4'd2;
    localparam logic [3:0] OP_STORE       = 4'd3;
    localparam logic [3:0] OP_JUMP        = 4'd4;
    localparam logic [3:0] OP_EQUAL_TO    = 4'd5;
    localparam logic [3:0] OP_RIGHT_SHIFT = 4'd6;
    localparam logic [3:0] OP_LEFT_SHIFT  = 4'd7;

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_AND = 3'd2;
    localparam logic [2:0] F_OR  = 3'd3;
    localparam logic [2:0] F_XOR = 3'd4;

    // Bit positions inside the 16-bit machine word
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 9;
    localparam int RS1_MSB  = 8;
    localparam int RS1_LSB  = 6;
    localparam int RS2_MSB  = 5;
    localparam int RS2_LSB  = 3;
    localparam int FN_MSB   = 2;
    localparam int FN_LSB   = 0;
    localparam int IMM_MSB  = 8;
    localparam int IMM_LSB  = 1;
    localparam int JIMM_MSB = 7;
    localparam int JIMM_LSB = 0;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } loader_state_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational packer turning decoded instruction fields into a 16-bit machine word;
// flags opcodes outside the ISA as illegal.
module instr_encoder
    import isa_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs1,
    input  logic [2:0]  rs2,
    input  logic [2:0]  funct,
    input  logic [7:0]  imm,
    output logic [15:0] word,
    output logic        illegal
);

    // Field packing by instruction format
    always_comb begin
        word    = 16'h0000;
        illegal = 1'b0;
        word[OP_MSB:OP_LSB] = opcode;
        case (opcode)
            OP_RTYPE, OP_EQUAL_TO, OP_RIGHT_SHIFT, OP_LEFT_SHIFT: begin
                word[RD_MSB:RD_LSB]   = rd;
                word[RS1_MSB:RS1_LSB] = rs1;
                word[RS2_MSB:RS2_LSB] = rs2;
                word[FN_MSB:FN_LSB]   = funct;
            end
            // STORE reuses the rd slot for its source register
            OP_LOAD_IM, OP_LOAD, OP_STORE: begin
                word[RD_MSB:RD_LSB]   = rd;
                word[IMM_MSB:IMM_LSB] = imm;
            end
            OP_JUMP: begin
                word[JIMM_MSB:JIMM_LSB] = imm;
            end
            default: begin
                word    = 16'h0000;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/program_loader.sv
// Streams encoded instructions into imem while holding the core in reset.
// Optional feature macro: LOADER_CHECKSUM_EN builds the running XOR checksum of written words.
module program_loader
    import isa_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_opcode,
    input  logic [2:0]         in_rd,
    input  logic [2:0]         in_rs1,
    input  logic [2:0]         in_rs2,
    input  logic [2:0]         in_funct,
    input  logic [7:0]         in_imm,
    input  logic               in_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [1:0]         err_code,
    output logic [INSTR_W-1:0] checksum
);

    localparam logic [IMEM_AW-1:0] ADDR_MAX = '1;
    localparam logic [IMEM_AW-1:0] ADDR_ONE = IMEM_AW'(1);

    loader_state_e      state_q, state_d;
    logic [IMEM_AW-1:0] addr_q, addr_d, tgt_s;
    logic               we_q, we_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic [1:0]         err_q, err_d;
    logic               ready_q, ready_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               errf_q, errf_d;
    logic [15:0]        word_s;
    logic               illegal_s;
    logic               accept_s;

    instr_encoder u_enc (
        .opcode  (in_opcode),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .funct   (in_funct),
        .imm     (in_imm),
        .word    (word_s),
        .illegal (illegal_s)
    );

    // Next-state, write pointer and write-port computation
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        err_d    = err_q;
        accept_s = (state_q == ST_LOAD) && in_valid;
        // imem_addr shows the word being written, then moves on; a write in flight shifts the target
        tgt_s    = we_q ? (addr_q + ADDR_ONE) : addr_q;
        if (start) begin
            state_d = ST_LOAD;
            addr_d  = '0;
            err_d   = ERR_NONE;
        end else begin
            if (we_q && (addr_q != ADDR_MAX)) begin
                addr_d = addr_q + ADDR_ONE;
            end else begin
                addr_d = addr_q;
            end
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: begin
                    if (accept_s) begin
                        if (illegal_s) begin
                            state_d = ST_ERR;
                            err_d   = ERR_ILLEGAL;
                        end else begin
                            we_d    = 1'b1;
                            wdata_d = word_s;
                            addr_d  = tgt_s;
                            if (in_last) begin
                                state_d = ST_DRAIN;
                            end else if (tgt_s == ADDR_MAX) begin
                                state_d = ST_ERR;
                                err_d   = ERR_OVERFLOW;
                            end else begin
                                state_d = ST_LOAD;
                            end
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_DRAIN: state_d = ST_DONE;
                ST_DONE:  state_d = ST_DONE;
                ST_ERR:   state_d = ST_ERR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the next state so they are registered
    always_comb begin
        ready_d = 1'b0;
        hold_d  = 1'b0;
        done_d  = 1'b0;
        errf_d  = 1'b0;
        case (state_d)
            ST_IDLE:  hold_d = 1'b0;
            ST_LOAD:  begin ready_d = 1'b1; hold_d = 1'b1; end
            ST_DRAIN: hold_d = 1'b1;
            ST_DONE:  done_d = 1'b1;
            ST_ERR:   begin hold_d = 1'b1; errf_d = 1'b1; end
            default:  hold_d = 1'b0;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= ERR_NONE;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            errf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            errf_q  <= errf_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] csum_q, csum_d;

    // Checksum folds in each word as its write lands; start clears it
    always_comb begin
        if (start) begin
            csum_d = '0;
        end else if (we_q) begin
            csum_d = csum_q ^ wdata_q;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = errf_q;
    assign err_code   = err_q;

endmodule

// File: doc/program_loader.md
# program_loader

Streams symbolic instructions into instruction memory before the core runs. It accepts instructions as decoded fields over a valid/ready handshake, packs them into 16-bit machine words, and writes them to consecutive imem addresses. It holds the core in reset while loading. It is the encoder/writer counterpart of the core's control-unit decode path, and sits between the host/debug port and the instruction memory.

## Interface
Parameters:
- IMEM_AW, 8: imem address width; depth is 2^IMEM_AW words.
- INSTR_W, 16: machine word width. Fixed by the ISA; do not override.

Ports:
- clk  in  1  system clock; only clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load at address 0.
- in_valid  in  1  an instruction beat is presented.
- in_ready  out  1  loader accepts the beat this cycle.
- in_opcode  in  4  opcode; legal values 0–7.
- in_rd  in  3  destination register.
- in_rs1  in  3  source register 1.
- in_rs2  in  3  source register 2.
- in_funct  in  3  ALU function (R-type only).
- in_imm  in  8  immediate or absolute address.
- in_last  in  1  final beat of the program.
- imem_we  out  1  imem write strobe.
- imem_addr  out  IMEM_AW  imem write address.
- imem_wdata  out  16  encoded word.
- cpu_hold  out  1  holds the core in reset.
- load_done  out  1  program loaded; core released.
- load_err  out  1  load aborted.
- err_code  out  2  error cause: 0 none, 1 illegal opcode, 2 overflow.
- checksum  out  16  XOR of all written words.

## Operation
Encoding rules:
- R-type (0), EQUAL_TO (5), RIGHT_SHIFT (6), LEFT_SHIFT (7): {op[15:12], rd[11:9], rs1[8:6], rs2[5:3], funct[2:0]}.
- LOAD_IM (1), LOAD (2), STORE (3): {op, rd, imm[8:1], 1'b0}. For STORE, the rd field carries the source register.
- JUMP (4): {op, 4'b0000, imm[7:0]}.
- Opcodes 8–15 are illegal.

State machine:
- IDLE: start → LOAD.
- LOAD: an accepted beat (in_valid & in_ready) is legal and not last → register the word and stay in LOAD.
- LOAD: an accepted beat is legal and last → DRAIN.
- LOAD: an accepted beat has an illegal opcode → ERR with err_code=1. That word is not written.
- LOAD: a legal non-last beat is written to address 2^IMEM_AW−1 → ERR with err_code=2. The word is written first.
- DRAIN → DONE (unconditional).
- DONE and ERR: sticky; start → LOAD.
- start in LOAD or DRAIN: restart at address 0, discard any pending word, clear the checksum.

Outputs per state:
- in_ready = 1 only in LOAD.
- cpu_hold = 1 in LOAD, DRAIN, ERR; 0 in IDLE and DONE.
- load_done = 1 only in DONE.
- load_err = 1 only in ERR.

Address and datapath:
- imem_addr starts at 0 and increments by 1 after each write; it never wraps within a load.
- checksum ^= imem_wdata on each write; cleared on start.

## Timing
- Reset values: state IDLE; in_ready, imem_we, cpu_hold, load_done, load_err = 0; imem_addr, imem_wdata, err_code, checksum = 0.
- Latency: a beat accepted at edge N drives imem_we/imem_addr/imem_wdata during cycle N+1. The write lands at edge N+1.
- Throughput: one beat per cycle, with back-to-back writes.
- The last word is written during DRAIN; load_done and cpu_hold=0 appear the cycle after, so the core never fetches a partially written word.
- in_valid without in_ready: the beat is ignored and must be held by the source.
- A reset mid-load abandons the load. imem contents are undefined, and cpu_hold=0 once reset is released (state IDLE).

## Configuration
LOADER_CHECKSUM_EN:
- Defined: the checksum logic described above is built.
- Undefined: checksum is tied to 0 and no register is inferred.

## Structure
- Package isa_pkg holds:
  - opcode constants (OP_RTYPE..OP_LEFT_SHIFT);
  - funct constants;
  - instruction field bit positions;
  - err_code values;
  - the loader state enum.
- Sub-module instr_encoder: combinational field packer plus legality check. Inputs are opcode/rd/rs1/rs2/funct/imm; outputs are word[15:0] and illegal.

## Test plan
- ADD r1,r2,r3 (op 0, funct 0) then in_last LOAD_IM r4,#0x5A → addr0=0x0298, addr1=0x18B4; load_done two cycles after the last accept.
- JUMP #0x3C alone with in_last → imem_wdata=0x403C at addr 0; cpu_hold falls one cycle after the write.
- in_opcode=9 as the second beat → no write for that beat; load_err=1, err_code=1; cpu_hold stays 1; imem_addr=1.
- IMEM_AW=2, four non-last beats → four writes to addresses 0–3, then err_code=2; in_ready=0.
- in_valid held with stalls (valid toggling), then start mid-load → restart at addr 0; checksum cleared; no spurious imem_we.
- With LOADER_CHECKSUM_EN, program 0x0298, 0x18B4 → checksum=0x1A2C. Without it, checksum=0.
